// File: rtl/mem_port_arbiter.sv
// Arbitrates one synchronous-read RAM between CPU fetch and load/store ports.
// Data port has priority, bounded by a fetch starvation counter; response one cycle after grant.
module mem_port_arbiter #(
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32,
  parameter int STARVE_MAX = 2
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                inst_req_i,
  input  logic [ADDR_W-1:0]   inst_addr_i,
  output logic                inst_gnt_o,
  output logic                inst_rvalid_o,
  output logic [DATA_W-1:0]   inst_rdata_o,
  input  logic                data_req_i,
  input  logic                data_we_i,
  input  logic [ADDR_W-1:0]   data_addr_i,
  input  logic [DATA_W/8-1:0] data_sel_i,
  input  logic [DATA_W-1:0]   data_wdata_i,
  output logic                data_gnt_o,
  output logic                data_rvalid_o,
  output logic [DATA_W-1:0]   data_rdata_o,
  output logic                ram_ce_o,
  output logic                ram_we_o,
  output logic [ADDR_W-1:0]   ram_addr_o,
  output logic [DATA_W/8-1:0] ram_sel_o,
  output logic [DATA_W-1:0]   ram_data_o,
  input  logic [DATA_W-1:0]   ram_data_i
);

  localparam int SEL_W = DATA_W / 8;
  // Keep the counter at least one bit wide so STARVE_MAX=0 still elaborates.
  localparam int CNT_W = (STARVE_MAX > 0) ? $clog2(STARVE_MAX + 1) : 1;

  typedef enum logic [1:0] {
    RSP_NONE,
    RSP_INST,
    RSP_DRD,
    RSP_DWR
  } rsp_e;

  rsp_e             rsp_q, rsp_d;
  logic [CNT_W-1:0] starve_q, starve_d;
  logic             starved;
  logic             inst_win;
  logic             data_win;

  always_comb begin
    starved  = (starve_q == CNT_W'(STARVE_MAX));
    inst_win = !rst && inst_req_i && (!data_req_i || starved);
    data_win = !rst && data_req_i && !inst_win;

    starve_d = starve_q;
    if (!inst_req_i || inst_win) begin
      starve_d = '0;
    end else if (data_win && !starved) begin
      starve_d = starve_q + CNT_W'(1);
    end

    rsp_d = RSP_NONE;
    if (inst_win) begin
      rsp_d = RSP_INST;
    end else if (data_win) begin
      rsp_d = data_we_i ? RSP_DWR : RSP_DRD;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rsp_q    <= RSP_NONE;
      starve_q <= '0;
    end else begin
      rsp_q    <= rsp_d;
      starve_q <= starve_d;
    end
  end

  always_comb begin
    inst_gnt_o = inst_win;
    data_gnt_o = data_win;

    ram_ce_o   = inst_win || data_win;
    ram_we_o   = data_win && data_we_i;
    ram_addr_o = '0;
    ram_sel_o  = '0;
    ram_data_o = '0;
    if (data_win) begin
      ram_addr_o = data_addr_i;
      ram_sel_o  = data_sel_i;
      ram_data_o = data_wdata_i;
    end else if (inst_win) begin
      ram_addr_o = inst_addr_i;
      ram_sel_o  = {SEL_W{1'b1}};
    end

    // Gating with rst hides a response still held in rsp_q on the reset cycle.
    inst_rvalid_o = !rst && (rsp_q == RSP_INST);
    data_rvalid_o = !rst && ((rsp_q == RSP_DRD) || (rsp_q == RSP_DWR));
    inst_rdata_o  = inst_rvalid_o ? ram_data_i : '0;
    data_rdata_o  = (!rst && (rsp_q == RSP_DRD)) ? ram_data_i : '0;
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Randomized bench for mem_port_arbiter: STARVE_MAX=2 and STARVE_MAX=0 instances
// driven in lock-step and compared each cycle against an integer reference model.
module tb_mem_port_arbiter;

  localparam int AW = 32;
  localparam int DW = 32;
  localparam int SW = DW / 8;

  logic          clk = 1'b0;
  logic          rst;
  logic          inst_req;
  logic [AW-1:0] inst_addr;
  logic          data_req;
  logic          data_we;
  logic [AW-1:0] data_addr;
  logic [SW-1:0] data_sel;
  logic [DW-1:0] data_wdata;
  logic [DW-1:0] ram_rdata;

  logic          inst_gnt    [2];
  logic          inst_rvalid [2];
  logic [DW-1:0] inst_rdata  [2];
  logic          data_gnt    [2];
  logic          data_rvalid [2];
  logic [DW-1:0] data_rdata  [2];
  logic          ram_ce      [2];
  logic          ram_we      [2];
  logic [AW-1:0] ram_addr    [2];
  logic [SW-1:0] ram_sel     [2];
  logic [DW-1:0] ram_wdata   [2];

  int n_checks = 0;
  int n_errors = 0;

  // Model state: consecutive lost conflicts and last issued access (0 none, 1 fetch, 2 load, 3 store)
  int smax   [2] = '{2, 0};
  int losses [2] = '{0, 0};
  int last   [2] = '{0, 0};

  always #5 clk = ~clk;

  mem_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .STARVE_MAX(2)) u_dut_s2 (
    .clk(clk), .rst(rst),
    .inst_req_i(inst_req), .inst_addr_i(inst_addr), .inst_gnt_o(inst_gnt[0]),
    .inst_rvalid_o(inst_rvalid[0]), .inst_rdata_o(inst_rdata[0]),
    .data_req_i(data_req), .data_we_i(data_we), .data_addr_i(data_addr),
    .data_sel_i(data_sel), .data_wdata_i(data_wdata), .data_gnt_o(data_gnt[0]),
    .data_rvalid_o(data_rvalid[0]), .data_rdata_o(data_rdata[0]),
    .ram_ce_o(ram_ce[0]), .ram_we_o(ram_we[0]), .ram_addr_o(ram_addr[0]),
    .ram_sel_o(ram_sel[0]), .ram_data_o(ram_wdata[0]), .ram_data_i(ram_rdata)
  );

  mem_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .STARVE_MAX(0)) u_dut_s0 (
    .clk(clk), .rst(rst),
    .inst_req_i(inst_req), .inst_addr_i(inst_addr), .inst_gnt_o(inst_gnt[1]),
    .inst_rvalid_o(inst_rvalid[1]), .inst_rdata_o(inst_rdata[1]),
    .data_req_i(data_req), .data_we_i(data_we), .data_addr_i(data_addr),
    .data_sel_i(data_sel), .data_wdata_i(data_wdata), .data_gnt_o(data_gnt[1]),
    .data_rvalid_o(data_rvalid[1]), .data_rdata_o(data_rdata[1]),
    .ram_ce_o(ram_ce[1]), .ram_we_o(ram_we[1]), .ram_addr_o(ram_addr[1]),
    .ram_sel_o(ram_sel[1]), .ram_data_o(ram_wdata[1]), .ram_data_i(ram_rdata)
  );

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic drive_cycle(input logic r, input logic ireq, input logic [AW-1:0] iaddr,
                             input logic dreq, input logic dwe, input logic [AW-1:0] daddr,
                             input logic [SW-1:0] dsel, input logic [DW-1:0] dwd,
                             input logic [DW-1:0] rd);
    bit    ig, dg;
    string p;
    @(negedge clk);
    rst = r; inst_req = ireq; inst_addr = iaddr;
    data_req = dreq; data_we = dwe; data_addr = daddr;
    data_sel = dsel; data_wdata = dwd; ram_rdata = rd;
    #1;
    for (int k = 0; k < 2; k++) begin
      p  = (k == 0) ? "s2." : "s0.";
      ig = !r && ireq && (!dreq || losses[k] >= smax[k]);
      dg = !r && dreq && !ig;
      check_eq({p, "inst_gnt"},    32'(inst_gnt[k]), 32'(ig));
      check_eq({p, "data_gnt"},    32'(data_gnt[k]), 32'(dg));
      check_eq({p, "ram_ce"},      32'(ram_ce[k]),   32'(ig || dg));
      check_eq({p, "ram_we"},      32'(ram_we[k]),   32'(dg && dwe));
      check_eq({p, "ram_addr"},    ram_addr[k],      dg ? daddr : (ig ? iaddr : 32'h0));
      check_eq({p, "ram_sel"},     32'(ram_sel[k]),  dg ? 32'(dsel) : (ig ? 32'hF : 32'h0));
      check_eq({p, "ram_wdata"},   ram_wdata[k],     dg ? dwd : 32'h0);
      check_eq({p, "inst_rvalid"}, 32'(inst_rvalid[k]), 32'(!r && last[k] == 1));
      check_eq({p, "inst_rdata"},  inst_rdata[k],    (!r && last[k] == 1) ? rd : 32'h0);
      check_eq({p, "data_rvalid"}, 32'(data_rvalid[k]), 32'(!r && last[k] >= 2));
      check_eq({p, "data_rdata"},  data_rdata[k],    (!r && last[k] == 2) ? rd : 32'h0);
      if (r) begin
        losses[k] = 0;
        last[k]   = 0;
      end else begin
        last[k] = ig ? 1 : (dg ? (dwe ? 3 : 2) : 0);
        if (!ireq || ig)  losses[k] = 0;
        else if (dg)      losses[k] = (losses[k] + 1 > smax[k]) ? smax[k] : losses[k] + 1;
      end
    end
  endtask

  initial begin
    rst = 1'b1; inst_req = 1'b0; inst_addr = '0; data_req = 1'b0; data_we = 1'b0;
    data_addr = '0; data_sel = '0; data_wdata = '0; ram_rdata = '0;

    drive_cycle(1, 1, 32'h44, 1, 1, 32'h88, 4'hF, 32'h1234, 32'h5555);
    drive_cycle(1, 0, 0, 0, 0, 0, 0, 0, 32'h6666);
    // fetch alone, then its response
    drive_cycle(0, 1, 32'h10, 0, 0, 0, 0, 0, 32'h0);
    drive_cycle(0, 0, 0, 0, 0, 0, 0, 0, 32'hCAFE0001);
    // store, then its response with zero rdata
    drive_cycle(0, 0, 0, 1, 1, 32'h20, 4'b0011, 32'hDEADBEEF, 32'h0);
    drive_cycle(0, 0, 0, 0, 0, 0, 0, 0, 32'hAAAA5555);
    // sustained conflict: D,D,I pattern for STARVE_MAX=2, all fetch for 0
    for (int i = 0; i < 9; i++)
      drive_cycle(0, 1, 32'h100 + 32'(i), 1, 0, 32'h200 + 32'(i), 4'hC, 32'h0, 32'h1000 + 32'(i));
    drive_cycle(0, 0, 0, 1, 0, 32'h300, 4'hF, 0, 32'h77);
    // load then fetch back-to-back
    drive_cycle(0, 0, 0, 1, 0, 32'h40, 4'hF, 0, 32'h0);
    drive_cycle(0, 1, 32'h50, 0, 0, 0, 0, 0, 32'hBEEF0040);
    drive_cycle(0, 0, 0, 0, 0, 0, 0, 0, 32'hBEEF0050);
    // grant followed by reset drops the response
    drive_cycle(0, 1, 32'h60, 1, 0, 32'h70, 4'hF, 0, 32'h0);
    drive_cycle(1, 1, 32'h60, 1, 1, 32'h70, 4'hF, 32'h9, 32'h11);
    drive_cycle(0, 0, 0, 0, 0, 0, 0, 0, 32'h22);

    for (int n = 0; n < 2000; n++) begin
      drive_cycle(($urandom_range(0, 39) == 0),
                  ($urandom_range(0, 9) < 8), $urandom(),
                  ($urandom_range(0, 9) < 8), $urandom_range(0, 1), $urandom(),
                  SW'($urandom()), $urandom(), $urandom());
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
